vertex_projection: RTL
======================

Name: vertex_projection

Overview:
- Downstream neighbour of the vertex transformation stage in the 3D rendering pipeline.
- Takes one camera-space vertex (x, y, z signed fixed point) per handshake and applies a perspective divide plus viewport mapping, producing integer screen coordinates, depth and status flags.
- Results feed triangle assembly/rasterisation; a vertex index tag passes through unchanged so faces can be resolved downstream.
- Iterative design: one shared sequential divider, roughly one vertex per 35 cycles.

Parameters:
- W, 16: coordinate width, signed two's complement, Q(W-FRAC).FRAC.
- FRAC, 8: fractional bits of coordinates.
- FOCAL, 256: focal length in pixels, integer.
- NUM_W, 32: divider numerator/quotient width; must satisfy FOCAL*2^(2*FRAC) < 2^NUM_W.
- NEAR_Z, 64: near-plane raw z value (0.25 at FRAC=8); must be >= 1.
- SCREEN_W, 640: screen width in pixels.
- SCREEN_H, 480: screen height in pixels.
- PIX_W, 12: screen coordinate width, unsigned.
- ID_W, 8: vertex index tag width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- s_valid  in  1  input vertex valid.
- s_ready  out  1  block can accept a vertex.
- s_x, s_y, s_z  in  W each  camera-space coordinates, signed raw.
- s_id  in  ID_W  vertex index tag.
- m_valid  out  1  projected vertex valid.
- m_ready  in  1  downstream accepts.
- m_sx, m_sy  out  PIX_W each  screen coordinates.
- m_depth  out  W  z passthrough, used for depth test.
- m_id  out  ID_W  tag passthrough.
- m_clip  out  1  vertex at or behind the near plane; sx/sy invalid (driven 0).
- m_offscreen  out  1  projected point fell outside the screen and was clamped.

Behaviour:
- FSM states: IDLE, DIV, MUL, OUT. s_ready = (state == IDLE), combinational from state only.
- Accept: s_valid && s_ready at edge k latches x, y, z, id.
  - If s_z <= NEAR_Z (signed compare): m_clip=1, m_sx=m_sy=0, m_offscreen=0; go to OUT; m_valid rises at k+1.
  - Otherwise: start the divider; go to DIV.
- DIV: unsigned restoring division inv = floor(FOCAL*2^(2*FRAC) / z), one quotient bit per cycle, NUM_W cycles. Divisor is always >= NEAR_Z+1, so no divide-by-zero.
- MUL: one cycle.
  - px = (x * inv) >>> (2*FRAC) and py = (y * inv) >>> (2*FRAC). Signed multiply with inv zero-extended; use full-width intermediates (W+NUM_W+1 bits); arithmetic shift floors toward minus infinity.
  - sx = SCREEN_W/2 + px; sy = SCREEN_H/2 - py.
  - Clamp each to [0, SCREEN_W-1] or [0, SCREEN_H-1] respectively; m_offscreen = 1 if either value was clamped.
- OUT: m_valid=1, and all m_* outputs are held stable until m_ready. On m_valid && m_ready, go to IDLE. The next accept is possible in the following cycle (no same-cycle turnaround).
- Latency: non-clipped vertex accepted at edge k gives m_valid at k+NUM_W+2 (34 with defaults). Clipped vertex gives m_valid at k+1.
- Reset values: state IDLE, m_valid 0, m_sx/m_sy/m_depth/m_id 0, m_clip 0, m_offscreen 0, divider idle. s_ready is 1 after reset.
- Reset asserted mid-DIV/MUL/OUT aborts the in-flight vertex with no output; any input offered in the reset cycle is ignored.
- Inputs change while not in IDLE: ignored, since the latched copies are used.
- m_ready held high continuously: one output cycle per vertex, no duplicates.

Decomposition:
- Package graphics_pkg holds:
  - W, FRAC, PIX_W, ID_W defaults;
  - screen-size constants;
  - the FSM state enum;
  - a vertex struct {x, y, z} shared with the transformation stage.
- Sub-module seq_udiv: parameterised unsigned restoring divider with start/busy/done, NUM_W iterations, quotient output held after done.

Test Plan:
- x=256, y=128, z=512, id=5 -> inv=32768; m_sx=448, m_sy=176, m_depth=512, m_id=5, clip=0, offscreen=0; m_valid exactly 34 cycles after accept.
- x=-256, y=-256, z=512 -> m_sx=192, m_sy=368, flags 0.
- z=64 (=NEAR_Z), then z=-100 -> m_clip=1, m_sx=m_sy=0, m_valid 1 cycle after accept; the non-clipped vertex following it projects correctly.
- x=1024, y=0, z=256 -> px=1024, m_sx clamped to 639, m_sy=240, m_offscreen=1.
- Backpressure: m_ready held 0 for 10 cycles in OUT -> outputs stable, s_ready=0 throughout; release -> single transfer, s_ready=1 next cycle.
- rst pulsed 1 cycle during DIV -> no m_valid for the aborted vertex; a fresh vertex afterwards gives correct results and latency.

Source files
------------

// File: rtl/graphics_pkg.sv
// -----------------------------------------------------------------------------
// graphics_pkg
//
// Purpose:
//   Shared definitions for the geometry front end of the 3D rendering
//   pipeline: default coordinate/tag/pixel widths, screen-size constants,
//   the projection FSM state encoding and the camera-space vertex record
//   exchanged with the transformation stage.
//
// Ports:
//   (package, no ports)
// -----------------------------------------------------------------------------
package graphics_pkg;

    // Default coordinate format: signed Q8.8 fixed point.
    localparam int COORD_W    = 16;
    localparam int COORD_FRAC = 8;

    // Default screen coordinate and vertex-tag widths.
    localparam int PIX_W_DEF  = 12;
    localparam int ID_W_DEF   = 8;

    // Default viewport size in pixels.
    localparam int SCREEN_W_DEF = 640;
    localparam int SCREEN_H_DEF = 480;

    // Projection FSM: idle, iterative divide, multiply/clamp, output hold.
    typedef enum logic [1:0] {
        PROJ_IDLE = 2'd0,
        PROJ_DIV  = 2'd1,
        PROJ_MUL  = 2'd2,
        PROJ_OUT  = 2'd3
    } proj_state_e;

    // Camera-space vertex as produced by the transformation stage.
    typedef struct packed {
        logic signed [COORD_W-1:0] x;
        logic signed [COORD_W-1:0] y;
        logic signed [COORD_W-1:0] z;
    } vertex_t;

endpackage

// File: rtl/seq_udiv.sv
// -----------------------------------------------------------------------------
// seq_udiv
//
// Purpose:
//   Unsigned restoring divider producing one quotient bit per clock.
//   The start cycle already performs the first iteration on the incoming
//   operands, so a full NUM_W-bit quotient takes NUM_W clock edges counting
//   the start edge. done_o pulses for one cycle once the quotient is complete
//   and quo_o then holds its value until the next start.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset
//   start_i  in   load operands and begin a division
//   num_i    in   NUM_W-bit dividend
//   den_i    in   DEN_W-bit divisor (must be non-zero, DEN_W <= NUM_W)
//   busy_o   out  division in progress
//   done_o   out  one-cycle pulse, quotient valid
//   quo_o    out  NUM_W-bit quotient, held after done
// -----------------------------------------------------------------------------
module seq_udiv #(
    parameter int NUM_W = 32,
    parameter int DEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [NUM_W-1:0] num_i,
    input  logic [DEN_W-1:0] den_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [NUM_W-1:0] quo_o
);

    localparam int CNT_W = $clog2(NUM_W + 1);

    logic [NUM_W-1:0] rem_q, rem_d;
    logic [NUM_W-1:0] quo_q, quo_d;
    logic [NUM_W-1:0] den_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;

    logic [NUM_W-1:0] cur_rem;
    logic [NUM_W-1:0] cur_quo;
    logic [NUM_W-1:0] cur_den;
    logic [NUM_W:0]   trial;
    logic [NUM_W:0]   diff;

    // One restoring-division step. On the start cycle the step works on the
    // fresh operands instead of the registers, which saves a cycle of latency.
    // The dividend is shifted out of the top of the quotient register while
    // quotient bits are shifted in at the bottom.
    always_comb begin
        cur_rem = start_i ? '0 : rem_q;
        cur_quo = start_i ? num_i : quo_q;
        cur_den = start_i ? NUM_W'(den_i) : den_q;
        trial   = {cur_rem, cur_quo[NUM_W-1]};
        diff    = trial - {1'b0, cur_den};
        rem_d   = trial[NUM_W-1:0];
        quo_d   = {cur_quo[NUM_W-2:0], 1'b0};
        if (!diff[NUM_W]) begin
            rem_d = diff[NUM_W-1:0];
            quo_d = {cur_quo[NUM_W-2:0], 1'b1};
        end
    end

    // Iteration control: the counter tracks how many quotient bits have been
    // produced; the last step clears busy and raises done for one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q  <= '0;
            quo_q  <= '0;
            den_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else if (start_i) begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            den_q  <= cur_den;
            cnt_q  <= CNT_W'(1);
            busy_q <= 1'b1;
            done_q <= 1'b0;
        end else if (busy_q) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(NUM_W - 1)) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
            end
        end else begin
            done_q <= 1'b0;
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign quo_o  = quo_q;

endmodule

// File: rtl/vertex_projection.sv
// -----------------------------------------------------------------------------
// vertex_projection
//
// Purpose:
//   Perspective divide plus viewport mapping for one camera-space vertex per
//   handshake. inv = floor(FOCAL * 2^(2*FRAC) / z) is computed by a shared
//   sequential divider, then px = (x*inv) >>> 2*FRAC, py likewise, and the
//   screen point (SCREEN_W/2 + px, SCREEN_H/2 - py) is clamped to the
//   viewport. Vertices at or behind the near plane skip the divide and are
//   flagged as clipped. Depth and the vertex tag pass through unchanged.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   s_valid      in   input vertex valid
//   s_ready      out  block can accept a vertex (idle)
//   s_x/s_y/s_z  in   camera-space coordinates, signed Q(W-FRAC).FRAC
//   s_id         in   vertex index tag
//   m_valid      out  projected vertex valid
//   m_ready      in   downstream accepts
//   m_sx/m_sy    out  screen coordinates, unsigned pixels
//   m_depth      out  z passthrough
//   m_id         out  tag passthrough
//   m_clip       out  vertex at or behind near plane, sx/sy forced to 0
//   m_offscreen  out  projected point was clamped to the screen edge
// -----------------------------------------------------------------------------
module vertex_projection
    import graphics_pkg::*;
#(
    parameter int W        = COORD_W,
    parameter int FRAC     = COORD_FRAC,
    parameter int FOCAL    = 256,
    parameter int NUM_W    = 32,
    parameter int NEAR_Z   = 64,
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int SCREEN_H = SCREEN_H_DEF,
    parameter int PIX_W    = PIX_W_DEF,
    parameter int ID_W     = ID_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic signed [W-1:0] s_x,
    input  logic signed [W-1:0] s_y,
    input  logic signed [W-1:0] s_z,
    input  logic [ID_W-1:0]     s_id,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [PIX_W-1:0]    m_sx,
    output logic [PIX_W-1:0]    m_sy,
    output logic [W-1:0]        m_depth,
    output logic [ID_W-1:0]     m_id,
    output logic                m_clip,
    output logic                m_offscreen
);

    // Product width large enough that x*inv never overflows.
    localparam int PW    = W + NUM_W + 1;
    localparam int SHIFT = 2 * FRAC;

    localparam logic [NUM_W-1:0]     NUMERATOR = NUM_W'(FOCAL) << SHIFT;
    localparam logic signed [W-1:0]  NEAR_Z_S  = W'(NEAR_Z);
    localparam logic signed [PW-1:0] HALF_W    = PW'(SCREEN_W / 2);
    localparam logic signed [PW-1:0] HALF_H    = PW'(SCREEN_H / 2);
    localparam logic signed [PW-1:0] MAX_X     = PW'(SCREEN_W - 1);
    localparam logic signed [PW-1:0] MAX_Y     = PW'(SCREEN_H - 1);

    proj_state_e state_q, state_d;

    logic signed [W-1:0] x_q;
    logic signed [W-1:0] y_q;
    logic [PIX_W-1:0]    m_sx_q;
    logic [PIX_W-1:0]    m_sy_q;
    logic [W-1:0]        m_depth_q;
    logic [ID_W-1:0]     m_id_q;
    logic                m_clip_q;
    logic                m_offscreen_q;

    logic             accept;
    logic             is_clip;
    logic             div_start;
    logic             div_busy;
    logic             div_done;
    logic [NUM_W-1:0] inv;

    logic signed [PW-1:0] x_ext, y_ext, inv_ext;
    logic signed [PW-1:0] prod_x, prod_y;
    logic signed [PW-1:0] px, py;
    logic signed [PW-1:0] sx_raw, sy_raw;
    logic [PIX_W-1:0]     sx_c, sy_c;
    logic                 off_c;

    assign s_ready   = (state_q == PROJ_IDLE);
    assign m_valid   = (state_q == PROJ_OUT);
    assign accept    = s_valid && s_ready;
    assign is_clip   = (s_z <= NEAR_Z_S);
    assign div_start = accept && !is_clip;

    // Divisor is the raw z; only vertices beyond the near plane start a divide,
    // so it is always positive and non-zero.
    seq_udiv #(
        .NUM_W (NUM_W),
        .DEN_W (W)
    ) u_div (
        .clk     (clk),
        .rst     (rst),
        .start_i (div_start),
        .num_i   (NUMERATOR),
        .den_i   (s_z),
        .busy_o  (div_busy),
        .done_o  (div_done),
        .quo_o   (inv)
    );

    // Projection arithmetic: signed coordinate times zero-extended reciprocal,
    // arithmetic shift floors toward minus infinity, then viewport offset and
    // per-axis clamping. Screen y grows downward, hence the subtraction.
    always_comb begin
        x_ext   = {{(PW-W){x_q[W-1]}}, x_q};
        y_ext   = {{(PW-W){y_q[W-1]}}, y_q};
        inv_ext = {{(PW-NUM_W){1'b0}}, inv};
        prod_x  = x_ext * inv_ext;
        prod_y  = y_ext * inv_ext;
        px      = prod_x >>> SHIFT;
        py      = prod_y >>> SHIFT;
        sx_raw  = HALF_W + px;
        sy_raw  = HALF_H - py;
        off_c   = 1'b0;
        sx_c    = sx_raw[PIX_W-1:0];
        sy_c    = sy_raw[PIX_W-1:0];
        if (sx_raw[PW-1]) begin
            sx_c  = '0;
            off_c = 1'b1;
        end else if (sx_raw > MAX_X) begin
            sx_c  = PIX_W'(SCREEN_W - 1);
            off_c = 1'b1;
        end
        if (sy_raw[PW-1]) begin
            sy_c  = '0;
            off_c = 1'b1;
        end else if (sy_raw > MAX_Y) begin
            sy_c  = PIX_W'(SCREEN_H - 1);
            off_c = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PROJ_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Clipped vertices skip straight to the output state.
    // Dropping out of DIV without done only happens if the divider was
    // somehow idle, and returning to IDLE avoids waiting forever.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            PROJ_IDLE: begin
                if (s_valid) begin
                    state_d = is_clip ? PROJ_OUT : PROJ_DIV;
                end
            end
            PROJ_DIV: begin
                if (div_done) begin
                    state_d = PROJ_MUL;
                end else if (!div_busy) begin
                    state_d = PROJ_IDLE;
                end
            end
            PROJ_MUL: begin
                state_d = PROJ_OUT;
            end
            PROJ_OUT: begin
                if (m_ready) begin
                    state_d = PROJ_IDLE;
                end
            end
            default: begin
                state_d = PROJ_IDLE;
            end
        endcase
    end

    // Vertex latch and output registers. Inputs are captured only on accept,
    // so later input changes cannot disturb an in-flight vertex; outputs only
    // change in IDLE or MUL and therefore stay frozen while waiting in OUT.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q           <= '0;
            y_q           <= '0;
            m_sx_q        <= '0;
            m_sy_q        <= '0;
            m_depth_q     <= '0;
            m_id_q        <= '0;
            m_clip_q      <= 1'b0;
            m_offscreen_q <= 1'b0;
        end else begin
            if (accept) begin
                x_q       <= s_x;
                y_q       <= s_y;
                m_depth_q <= s_z;
                m_id_q    <= s_id;
                if (is_clip) begin
                    m_sx_q        <= '0;
                    m_sy_q        <= '0;
                    m_clip_q      <= 1'b1;
                    m_offscreen_q <= 1'b0;
                end
            end
            if (state_q == PROJ_MUL) begin
                m_sx_q        <= sx_c;
                m_sy_q        <= sy_c;
                m_clip_q      <= 1'b0;
                m_offscreen_q <= off_c;
            end
        end
    end

    assign m_sx        = m_sx_q;
    assign m_sy        = m_sy_q;
    assign m_depth     = m_depth_q;
    assign m_id        = m_id_q;
    assign m_clip      = m_clip_q;
    assign m_offscreen = m_offscreen_q;

endmodule
